// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, state encoding, result entry and golden ALU model
package alu_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [2:0] y;
        logic [1:0] op;
        logic       err;
    } res_entry_t;

    // Reference result for the 2-bit ALU; subtraction wraps modulo 8.
    function automatic logic [2:0] alu_expected(input logic [1:0] a,
                                                input logic [1:0] b,
                                                input logic [1:0] op);
        logic [2:0] r;
        case (op)
            ALU_ADD: r = {1'b0, a} + {1'b0, b};
            ALU_SUB: r = {1'b0, a} - {1'b0, b};
            ALU_AND: r = {1'b0, a & b};
            default: r = {1'b0, a | b};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - synchronous show-ahead FIFO with occupancy count
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 6
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [W-1:0]               i_wdata,
    input  logic                       i_pop,
    output logic [W-1:0]               o_rdata,
    output logic                       o_valid,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    // Pops on an empty FIFO and pushes on a full one are dropped.
    assign w_do_push = i_push && (r_count != FULL_CNT);
    assign w_do_pop  = i_pop  && (r_count != '0);

    // Head is presented combinationally; zero when nothing is buffered.
    assign o_valid = (r_count != '0);
    assign o_rdata = o_valid ? r_mem[r_rd] : '0;
    assign o_count = r_count;

    // Storage, pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= i_wdata;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - drives a 2-bit ALU, checks each result and queues it downstream
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_a,
    input  logic [1:0]       cmd_b,
    input  logic [1:0]       cmd_op,
    output logic [1:0]       alu_a,
    output logic [1:0]       alu_b,
    output logic [1:0]       alu_op,
    input  logic [2:0]       alu_y,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [2:0]       res_y,
    output logic [1:0]       res_op,
    output logic             res_err,
    output logic             err_sticky,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam logic [FW:0] FIFO_FULL = (FW+1)'(FIFO_DEPTH);

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_settle;
    logic [1:0]       r_a;
    logic [1:0]       r_b;
    logic [1:0]       r_op;
    logic [2:0]       r_exp;
    logic             r_sticky;
    logic [CNT_W-1:0] r_count;
    logic             w_cmd_ready;
    logic             w_busy;
    logic             w_accept;
    logic             w_done;
    logic [FW:0]      w_fifo_count;
    res_entry_t       w_push_entry;
    res_entry_t       w_head;

    assign w_accept = cmd_valid && w_cmd_ready;
    assign w_done   = (r_state == WAIT) && (r_settle == '0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and handshake outputs; ready is held low while reset is asserted.
    always_comb begin
        w_next      = r_state;
        w_cmd_ready = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                w_cmd_ready = rst_n && (w_fifo_count < FIFO_FULL);
                if (cmd_valid && w_cmd_ready) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                w_busy = 1'b1;
                if (r_settle == '0) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Operand/opcode registers and golden result latch on accept; settle countdown in WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_exp    <= '0;
            r_settle <= '0;
        end else if (w_accept) begin
            r_a      <= cmd_a;
            r_b      <= cmd_b;
            r_op     <= cmd_op;
            r_exp    <= alu_expected(cmd_a, cmd_b, cmd_op);
            r_settle <= SETTLE_LOAD;
        end else if ((r_state == WAIT) && (r_settle != '0)) begin
            r_settle <= r_settle - CW'(1);
        end
    end

    // Completion bookkeeping: sticky mismatch flag and wrapping operation counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky <= 1'b0;
            r_count  <= '0;
        end else if (w_done) begin
            r_count <= r_count + CNT_W'(1);
            if (w_push_entry.err) begin
                r_sticky <= 1'b1;
            end
        end
    end

    assign w_push_entry = '{y: alu_y, op: r_op, err: (alu_y != r_exp)};

    alu_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     ($bits(res_entry_t))
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_push  (w_done),
        .i_wdata (w_push_entry),
        .i_pop   (res_ready),
        .o_rdata (w_head),
        .o_valid (res_valid),
        .o_count (w_fifo_count)
    );

    assign cmd_ready  = w_cmd_ready;
    assign busy       = w_busy;
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_op     = r_op;
    assign res_y      = w_head.y;
    assign res_op     = w_head.op;
    assign res_err    = w_head.err;
    assign err_sticky = r_sticky;
    assign op_count   = r_count;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench with a transaction-level reference model
module tb_alu_op_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_a, cmd_b, cmd_op;
    logic [1:0] alu_a, alu_b, alu_op;
    logic [2:0] alu_y;
    logic       res_valid, res_ready, res_err, err_sticky, busy;
    logic [2:0] res_y;
    logic [1:0] res_op;
    logic [7:0] op_count;
    logic       fault;

    logic       cmd_valid3, cmd_ready3;
    logic [1:0] cmd_a3, cmd_b3, cmd_op3;
    logic [1:0] alu_a3, alu_b3, alu_op3;
    logic [2:0] alu_y3;
    logic       res_valid3, res_ready3, res_err3, err_sticky3, busy3;
    logic [2:0] res_y3;
    logic [1:0] res_op3;
    logic [7:0] op_count3;
    logic       ovr3_en;
    logic [2:0] ovr3_val;

    int checks = 0;
    int failures = 0;

    function automatic bit [2:0] tb_gold(input bit [1:0] a, input bit [1:0] b, input bit [1:0] op);
        int ia = a;
        int ib = b;
        case (op)
            2'd0:    return 3'(ia + ib);
            2'd1:    return 3'((ia - ib + 8) % 8);
            2'd2:    return 3'(a & b);
            default: return 3'(a | b);
        endcase
    endfunction

    assign alu_y  = fault ? 3'b000 : tb_gold(alu_a, alu_b, alu_op);
    assign alu_y3 = ovr3_en ? ovr3_val : tb_gold(alu_a3, alu_b3, alu_op3);

    alu_op_sequencer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(1), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_y(res_y), .res_op(res_op), .res_err(res_err),
        .err_sticky(err_sticky), .busy(busy), .op_count(op_count)
    );

    alu_op_sequencer #(.FIFO_DEPTH(4), .SETTLE_CYCLES(3), .CNT_W(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_a(cmd_a3), .cmd_b(cmd_b3), .cmd_op(cmd_op3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3), .alu_y(alu_y3),
        .res_valid(res_valid3), .res_ready(res_ready3),
        .res_y(res_y3), .res_op(res_op3), .res_err(res_err3),
        .err_sticky(err_sticky3), .busy(busy3), .op_count(op_count3)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model for u_dut: one op in flight, results queued in order.
    typedef struct {
        bit [2:0] y;
        bit [1:0] op;
        bit       err;
    } ent_t;

    ent_t     mq[$];
    bit       m_inflight = 0;
    int       m_rem = 0;
    bit [1:0] m_a = 0, m_b = 0, m_op = 0;
    bit       m_sticky = 0;
    bit [7:0] m_count = 0;

    always @(posedge clk) begin
        int   pre;
        bit   rdy;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
            m_inflight = 0;
            m_rem = 0;
            m_a = 0; m_b = 0; m_op = 0;
            m_sticky = 0;
            m_count = 0;
        end else begin
            pre = mq.size();
            rdy = !m_inflight && (pre < 4);
            if (pre > 0 && res_ready) void'(mq.pop_front());
            if (m_inflight) begin
                m_rem--;
                if (m_rem == 0) begin
                    e.y   = fault ? 3'b000 : tb_gold(m_a, m_b, m_op);
                    e.op  = m_op;
                    e.err = (e.y != tb_gold(m_a, m_b, m_op));
                    mq.push_back(e);
                    if (e.err) m_sticky = 1;
                    m_count++;
                    m_inflight = 0;
                end
            end else if (rdy && cmd_valid) begin
                m_a = cmd_a; m_b = cmd_b; m_op = cmd_op;
                m_inflight = 1;
                m_rem = 1;
            end
        end
        #1;
        chk("m_cmd_ready", int'(cmd_ready), int'(rst_n && !m_inflight && mq.size() < 4));
        chk("m_busy", int'(busy), int'(m_inflight));
        chk("m_res_valid", int'(res_valid), int'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("m_res_y", int'(res_y), int'(mq[0].y));
            chk("m_res_op", int'(res_op), int'(mq[0].op));
            chk("m_res_err", int'(res_err), int'(mq[0].err));
        end
        chk("m_err_sticky", int'(err_sticky), int'(m_sticky));
        chk("m_op_count", int'(op_count), int'(m_count));
        chk("m_alu_a", int'(alu_a), int'(m_a));
        chk("m_alu_b", int'(alu_b), int'(m_b));
        chk("m_alu_op", int'(alu_op), int'(m_op));
    end

    task automatic try_send(input bit [1:0] a, input bit [1:0] b, input bit [1:0] op,
                            input int max, output bit ok);
        bit r;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_a = a; cmd_b = b; cmd_op = op;
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            r = cmd_ready;
            @(negedge clk);
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic send(input bit [1:0] a, input bit [1:0] b, input bit [1:0] op);
        bit ok;
        try_send(a, b, op, 20, ok);
        chk("send_accept", int'(ok), 1);
    endtask

    task automatic op_check(input string name, input bit [1:0] a, input bit [1:0] b,
                            input bit [1:0] op, input int exp_y);
        send(a, b, op);
        @(negedge clk);
        chk({name, "_y"}, int'(res_y), exp_y);
        chk({name, "_op"}, int'(res_op), int'(op));
        chk({name, "_err"}, int'(res_err), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        bit ok;
        rst_n = 1'b0;
        cmd_valid = 0; cmd_a = 0; cmd_b = 0; cmd_op = 0; res_ready = 1; fault = 0;
        cmd_valid3 = 0; cmd_a3 = 0; cmd_b3 = 0; cmd_op3 = 0; res_ready3 = 1;
        ovr3_en = 0; ovr3_val = 0;

        #2;
        chk("rst_cmd_ready", int'(cmd_ready), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_res_y", int'(res_y), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_op_count", int'(op_count), 0);
        chk("rst_alu_a", int'(alu_a), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single add 3+3 with correct ALU
        send(2'd3, 2'd3, 2'b00);
        chk("add_alu_a", int'(alu_a), 3);
        chk("add_alu_b", int'(alu_b), 3);
        chk("add_busy", int'(busy), 1);
        chk("add_res_valid_early", int'(res_valid), 0);
        @(negedge clk);
        chk("add_res_valid", int'(res_valid), 1);
        chk("add_res_y", int'(res_y), 6);
        chk("add_res_err", int'(res_err), 0);
        chk("add_op_count", int'(op_count), 1);

        op_check("sub_wrap", 2'd1, 2'd2, 2'b01, 7);
        op_check("and", 2'd2, 2'd3, 2'b10, 2);
        op_check("or", 2'd2, 2'd3, 2'b11, 3);
        chk("count_after4", int'(op_count), 4);

        // Fault injection
        fault = 1'b1;
        send(2'd1, 2'd1, 2'b00);
        @(negedge clk);
        fault = 1'b0;
        chk("fault_res_y", int'(res_y), 0);
        chk("fault_res_err", int'(res_err), 1);
        chk("fault_sticky", int'(err_sticky), 1);
        send(2'd2, 2'd1, 2'b00);
        @(negedge clk);
        chk("post_fault_y", int'(res_y), 3);
        chk("post_fault_err", int'(res_err), 0);
        chk("post_fault_sticky", int'(err_sticky), 1);

        // Backpressure: six commands, only four fit
        @(negedge clk);
        res_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            try_send(2'(i), 2'(i + 1), 2'(i % 4), 6, ok);
            acc += int'(ok);
        end
        chk("bp_accepted", acc, 4);
        chk("bp_cmd_ready", int'(cmd_ready), 0);
        chk("bp_head_y", int'(res_y), 1);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("bp_head_after_pop", int'(res_y), 7);
        try_send(2'd1, 2'd1, 2'b11, 6, ok);
        chk("bp_one_more", int'(ok), 1);
        repeat (2) @(negedge clk);
        chk("bp_full_again", int'(cmd_ready), 0);
        res_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("bp_drained", int'(res_valid), 0);

        // Reset while an operation is in flight
        send(2'd3, 2'd2, 2'b00);
        chk("mid_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_cmd_ready", int'(cmd_ready), 0);
        chk("mid_rst_count", int'(op_count), 0);
        chk("mid_rst_sticky", int'(err_sticky), 0);
        chk("mid_rst_valid", int'(res_valid), 0);
        chk("mid_rst_alu_a", int'(alu_a), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rel_count", int'(op_count), 0);
        chk("mid_rel_valid", int'(res_valid), 0);

        // SETTLE_CYCLES=3 instance: mid-settle change of alu_y must be ignored
        @(negedge clk);
        cmd_valid3 = 1'b1; cmd_a3 = 2'd1; cmd_b3 = 2'd1; cmd_op3 = 2'b00;
        @(posedge clk); #1;
        chk("s3_busy_T", int'(busy3), 1);
        chk("s3_ready_T", int'(cmd_ready3), 0);
        @(negedge clk);
        cmd_valid3 = 1'b0;
        ovr3_en = 1'b1; ovr3_val = 3'b101;
        @(posedge clk); #1;
        chk("s3_busy_T1", int'(busy3), 1);
        chk("s3_valid_T1", int'(res_valid3), 0);
        @(negedge clk);
        ovr3_en = 1'b0;
        @(posedge clk); #1;
        chk("s3_busy_T2", int'(busy3), 1);
        chk("s3_valid_T2", int'(res_valid3), 0);
        @(posedge clk); #1;
        chk("s3_busy_T3", int'(busy3), 0);
        chk("s3_valid_T3", int'(res_valid3), 1);
        chk("s3_res_y", int'(res_y3), 2);
        chk("s3_res_err", int'(res_err3), 0);
        chk("s3_op_count", int'(op_count3), 1);

        // op_count wrap
        for (int i = 0; i < 255; i++) send(2'd1, 2'd0, 2'b00);
        @(negedge clk);
        chk("count_255", int'(op_count), 255);
        send(2'd1, 2'd0, 2'b00);
        @(negedge clk);
        chk("count_wrap", int'(op_count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
